// File: rtl/fifo_prog_thresh.sv
// Parameterised synchronous FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, pop-valid strobe and sticky overflow/underflow flags.
module fifo_prog_thresh #(
   parameter  int DATA_SIZE = 8,
   parameter  int MAIN_SIZE = 4,
   localparam int ADDR_W    = $clog2(MAIN_SIZE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic                 read,
   input  logic [DATA_SIZE-1:0] data_in_push,
   input  logic [ADDR_W:0]      af_thresh,
   input  logic [ADDR_W:0]      ae_thresh,
   input  logic                 err_clr,
   output logic [DATA_SIZE-1:0] data_out_pop,
   output logic                 pop_valid,
   output logic [ADDR_W:0]      fifo_count,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 fifo_error,
   output logic                 overflow_err,
   output logic                 underflow_err
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(MAIN_SIZE);
   localparam logic [ADDR_W:0]   ZERO_CNT = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

   logic [DATA_SIZE-1:0] mem_r [MAIN_SIZE];
   logic [ADDR_W-1:0]    wr_ptr_r;
   logic [ADDR_W-1:0]    rd_ptr_r;
   logic [ADDR_W:0]      count_r;
   logic [DATA_SIZE-1:0] dout_r;
   logic                 pop_valid_r;
   logic                 ovf_r;
   logic                 unf_r;

   logic full_s;
   logic empty_s;
   logic rd_acc_s;
   logic wr_acc_s;
   logic wr_rej_s;
   logic rd_rej_s;

   // Accept/reject decode; a pop on a full FIFO frees the slot the same cycle.
   always_comb begin
      full_s   = (count_r == FULL_CNT);
      empty_s  = (count_r == ZERO_CNT);
      rd_acc_s = read && !empty_s;
      wr_acc_s = write && (!full_s || rd_acc_s);
      wr_rej_s = write && !wr_acc_s;
      rd_rej_s = read && !rd_acc_s;
   end

   // Status flags are forced to their idle values while reset is asserted.
   assign fifo_full    = reset && full_s;
   assign fifo_empty   = !reset || empty_s;
   assign almost_full  = reset && (count_r >= af_thresh) && !full_s;
   assign almost_empty = reset && !empty_s && (count_r <= ae_thresh);
   assign fifo_error   = reset && (wr_rej_s || rd_rej_s);

   assign data_out_pop  = dout_r;
   assign pop_valid     = pop_valid_r;
   assign fifo_count    = count_r;
   assign overflow_err  = ovf_r;
   assign underflow_err = unf_r;

   // Storage array; intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= data_in_push;
      end
   end

   // Pointers, occupancy, pop data and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r    <= {ADDR_W{1'b0}};
         rd_ptr_r    <= {ADDR_W{1'b0}};
         count_r     <= ZERO_CNT;
         dout_r      <= {DATA_SIZE{1'b0}};
         pop_valid_r <= 1'b0;
         ovf_r       <= 1'b0;
         unf_r       <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end

         if (rd_acc_s) begin
            rd_ptr_r    <= rd_ptr_r + ONE_PTR;
            dout_r      <= mem_r[rd_ptr_r];
            pop_valid_r <= 1'b1;
         end else begin
            rd_ptr_r    <= rd_ptr_r;
            dout_r      <= dout_r;
            pop_valid_r <= 1'b0;
         end

         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_r <= count_r + ONE_CNT;
            2'b01:   count_r <= count_r - ONE_CNT;
            default: count_r <= count_r;
         endcase

         // A new error of the same type wins over a coincident clear.
         if (wr_rej_s) begin
            ovf_r <= 1'b1;
         end else if (err_clr) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end

         if (rd_rej_s) begin
            unf_r <= 1'b1;
         end else if (err_clr) begin
            unf_r <= 1'b0;
         end else begin
            unf_r <= unf_r;
         end
      end
   end

endmodule

// File: tb/tb_fifo_prog_thresh.sv
// Directed self-checking bench for fifo_prog_thresh (MAIN_SIZE=4, DATA_SIZE=8).
module tb_fifo_prog_thresh;

   logic       clk;
   logic       reset;
   logic       write;
   logic       read;
   logic [7:0] data_in_push;
   logic [2:0] af_thresh;
   logic [2:0] ae_thresh;
   logic       err_clr;
   logic [7:0] data_out_pop;
   logic       pop_valid;
   logic [2:0] fifo_count;
   logic       fifo_full;
   logic       fifo_empty;
   logic       almost_full;
   logic       almost_empty;
   logic       fifo_error;
   logic       overflow_err;
   logic       underflow_err;

   int errors = 0;
   int checks = 0;

   fifo_prog_thresh #(.DATA_SIZE(8), .MAIN_SIZE(4)) dut (
      .clk(clk), .reset(reset), .write(write), .read(read),
      .data_in_push(data_in_push), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .err_clr(err_clr), .data_out_pop(data_out_pop), .pop_valid(pop_valid),
      .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .fifo_error(fifo_error),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write = 1'b0; read = 1'b0; err_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; write = 1'b1; read = 1'b1; data_in_push = 8'h00; err_clr = 1'b0;
      af_thresh = 3'd3; ae_thresh = 3'd1;
      #12;
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
      checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("FAIL rst_empty_full got %b%b exp 10", fifo_empty, fifo_full); end
      checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin errors++; $display("FAIL rst_almost got %b%b exp 00", almost_full, almost_empty); end
      checks++; if (fifo_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", fifo_error); end
      checks++; if (pop_valid !== 1'b0 || data_out_pop !== 8'h00) begin errors++; $display("FAIL rst_pop got %b/%h exp 0/00", pop_valid, data_out_pop); end
      checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin errors++; $display("FAIL rst_sticky got %b%b exp 00", overflow_err, underflow_err); end
      idle();
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_fill_flags();
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 8'h11 * 8'(i + 1);
         write = 1'b1; data_in_push = d;
         step();
         checks++; if (fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, fifo_count, i + 1); end
         checks++; if (almost_empty !== (i == 0)) begin errors++; $display("FAIL fill_ae[%0d] got %b exp %b", i, almost_empty, (i == 0)); end
         checks++; if (almost_full !== (i == 2)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i == 2)); end
         checks++; if (fifo_full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, fifo_full, (i == 3)); end
      end
      idle();
   endtask

   task automatic test_order();
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 8'h11 * 8'(i + 1);
         read = 1'b1;
         step();
         checks++; if (pop_valid !== 1'b1 || data_out_pop !== d) begin errors++; $display("FAIL order_pop[%0d] got %b/%h exp 1/%h", i, pop_valid, data_out_pop, d); end
      end
      idle();
      step();
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL order_strobe got %b exp 0", pop_valid); end
      checks++; if (fifo_empty !== 1'b1 || fifo_count !== 3'd0) begin errors++; $display("FAIL order_empty got %b/%0d exp 1/0", fifo_empty, fifo_count); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i <= 10; i++) begin
         write = (i < 10); read = (i > 0); data_in_push = 8'(i);
         step();
         if (i > 0) begin
            checks++; if (pop_valid !== 1'b1 || data_out_pop !== 8'(i - 1)) begin errors++; $display("FAIL wrap_pop[%0d] got %b/%h exp 1/%h", i, pop_valid, data_out_pop, 8'(i - 1)); end
         end
         checks++; if (fifo_count !== ((i < 10) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL wrap_count[%0d] got %0d", i, fifo_count); end
      end
      idle();
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 4; i++) begin
         write = 1'b1; data_in_push = base + 8'(i);
         step();
      end
      idle();
   endtask

   task automatic test_full_rw();
      logic [7:0] exp_q [4];
      exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3; exp_q[3] = 8'hB0;
      fill(8'hA0);
      write = 1'b1; read = 1'b1; data_in_push = 8'hB0;
      #1;
      checks++; if (fifo_error !== 1'b0) begin errors++; $display("FAIL fullrw_error got %b exp 0", fifo_error); end
      step();
      idle();
      checks++; if (data_out_pop !== 8'hA0 || fifo_count !== 3'd4) begin errors++; $display("FAIL fullrw_pop got %h/%0d exp A0/4", data_out_pop, fifo_count); end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got %b exp 0", overflow_err); end
      for (int i = 0; i < 4; i++) begin
         read = 1'b1;
         step();
         checks++; if (data_out_pop !== exp_q[i]) begin errors++; $display("FAIL fullrw_drain[%0d] got %h exp %h", i, data_out_pop, exp_q[i]); end
      end
      idle();
   endtask

   task automatic test_errors();
      fill(8'hC0);
      write = 1'b1; data_in_push = 8'hFF;
      #1;
      checks++; if (fifo_error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b exp 1", fifo_error); end
      step();
      idle();
      checks++; if (overflow_err !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_set got %b/%0d exp 1/4", overflow_err, fifo_count); end
      step();
      checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_err); end
      for (int i = 0; i < 4; i++) begin
         read = 1'b1;
         step();
         checks++; if (data_out_pop !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, data_out_pop, 8'hC0 + 8'(i)); end
      end
      // Empty: read rejected, no pop.
      step();
      checks++; if (underflow_err !== 1'b1 || pop_valid !== 1'b0) begin errors++; $display("FAIL unf_set got %b/%b exp 1/0", underflow_err, pop_valid); end
      err_clr = 1'b1;
      step();
      checks++; if (underflow_err !== 1'b1 || overflow_err !== 1'b0) begin errors++; $display("FAIL clr_vs_unf got %b/%b exp 1/0", underflow_err, overflow_err); end
      read = 1'b0;
      step();
      checks++; if (underflow_err !== 1'b0 || overflow_err !== 1'b0) begin errors++; $display("FAIL clr_alone got %b/%b exp 0/0", underflow_err, overflow_err); end
      // Empty read+write: write accepted, read rejected, no fall-through.
      err_clr = 1'b0; write = 1'b1; read = 1'b1; data_in_push = 8'h77;
      step();
      idle();
      checks++; if (fifo_count !== 3'd1 || pop_valid !== 1'b0 || underflow_err !== 1'b1) begin errors++; $display("FAIL empty_rw got %0d/%b/%b exp 1/0/1", fifo_count, pop_valid, underflow_err); end
      read = 1'b1;
      step();
      checks++; if (data_out_pop !== 8'h77) begin errors++; $display("FAIL empty_rw_pop got %h exp 77", data_out_pop); end
      idle(); err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   task automatic test_async_reset();
      write = 1'b1; data_in_push = 8'h01;
      step();
      data_in_push = 8'h02;
      step();
      read = 1'b1; data_in_push = 8'h03;
      step();
      idle();
      checks++; if (fifo_count !== 3'd2 || pop_valid !== 1'b1 || data_out_pop !== 8'h01) begin errors++; $display("FAIL arst_pre got %0d/%b/%h exp 2/1/01", fifo_count, pop_valid, data_out_pop); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (fifo_count !== 3'd0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL arst_count got %0d/%b exp 0/1", fifo_count, fifo_empty); end
      checks++; if (pop_valid !== 1'b0 || data_out_pop !== 8'h00) begin errors++; $display("FAIL arst_pop got %b/%h exp 0/00", pop_valid, data_out_pop); end
      @(negedge clk);
      reset = 1'b1;
      step();
      write = 1'b1; data_in_push = 8'h5A;
      step();
      write = 1'b0; read = 1'b1;
      step();
      idle();
      checks++; if (pop_valid !== 1'b1 || data_out_pop !== 8'h5A) begin errors++; $display("FAIL arst_after got %b/%h exp 1/5A", pop_valid, data_out_pop); end
   endtask

   task automatic test_thresh();
      write = 1'b1; data_in_push = 8'h10;
      step();
      data_in_push = 8'h20;
      step();
      idle();
      checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin errors++; $display("FAIL thr_before got %b%b exp 00", almost_full, almost_empty); end
      af_thresh = 3'd2;
      #1;
      checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL thr_af got %b exp 1", almost_full); end
      ae_thresh = 3'd2;
      #1;
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL thr_ae got %b exp 1", almost_empty); end
      af_thresh = 3'd3; ae_thresh = 3'd1;
      #1;
      checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin errors++; $display("FAIL thr_restore got %b%b exp 00", almost_full, almost_empty); end
   endtask

   initial begin
      test_reset();
      test_fill_flags();
      test_order();
      test_wrap();
      test_full_rw();
      test_errors();
      test_async_reset();
      test_thresh();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
